// File: rtl/gc_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : gc_dispatcher
// Description : Hands out loop indices (gc, stride gd) of a parallel section
//               to N_CORE cores, detects exhaustion and signals join.
//               Optional rotating grant priority: GC_DISPATCH_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module gc_dispatcher #(
    parameter int N_CORE    = 4,
    parameter int GC_WIDTH  = 32,
    parameter int GD_WIDTH  = 32,
    parameter int MAX_GRANT = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fork_valid,
    output logic                         fork_ready,
    input  logic [GC_WIDTH-1:0]          fork_gc,
    input  logic [GD_WIDTH-1:0]          fork_gd,
    input  logic [GC_WIDTH-1:0]          fork_bound,
    output logic                         parallel,
    output logic                         gd_sign,
    input  logic [N_CORE-1:0]            req_valid,
    output logic [N_CORE-1:0]            req_ready,
    output logic [N_CORE*GC_WIDTH-1:0]   gc_out,
    output logic [N_CORE-1:0]            gc_done,
    input  logic [N_CORE-2:0]            ending,
    output logic                         join_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        JOIN = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic signed [GC_WIDTH-1:0]  gc_q, gc_d;
    logic signed [GC_WIDTH-1:0]  bound_q, bound_d;
    logic signed [GD_WIDTH-1:0]  gd_q, gd_d;
    logic [N_CORE-1:0]           done_seen_q, done_seen_d;
    logic                        exhausted_q, exhausted_d;

    logic signed [GC_WIDTH-1:0]  gd_ext;
    logic signed [GC_WIDTH-1:0]  cur;
    logic                        frozen;
    int                          slots;
    int                          idx;

`ifdef GC_DISPATCH_RR_EN
    localparam int PTR_W = (N_CORE > 1) ? $clog2(N_CORE) : 1;
    logic [PTR_W-1:0]            ptr_q, ptr_d;
    int                          last;
    logic                        any_grant;
`endif

    function automatic logic out_of_range(input logic signed [GC_WIDTH-1:0] v,
                                          input logic signed [GC_WIDTH-1:0] b,
                                          input logic                       neg);
        return neg ? (v <= b) : (v >= b);
    endfunction

    assign gd_ext   = GC_WIDTH'(gd_q);
    assign parallel = (state_q != IDLE);
    assign gd_sign  = gd_q[GD_WIDTH-1];

    always_comb begin
        state_d     = state_q;
        gc_d        = gc_q;
        gd_d        = gd_q;
        bound_d     = bound_q;
        done_seen_d = done_seen_q;
        exhausted_d = exhausted_q;
        fork_ready  = 1'b0;
        req_ready   = '0;
        gc_out      = '0;
        gc_done     = '0;
        join_valid  = 1'b0;
        cur         = gc_q;
        frozen      = exhausted_q;
        slots       = 0;
        idx         = 0;
`ifdef GC_DISPATCH_RR_EN
        ptr_d       = ptr_q;
        last        = 0;
        any_grant   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                fork_ready = 1'b1;
                if (fork_valid) begin
                    gc_d        = fork_gc;
                    gd_d        = fork_gd;
                    bound_d     = fork_bound;
                    done_seen_d = '0;
                    exhausted_d = 1'b0;
`ifdef GC_DISPATCH_RR_EN
                    ptr_d       = '0;
`endif
                    state_d     = RUN;
                end
            end
            RUN: begin
                // cur walks gc + k*gd; it sticks at the first out-of-range index
                for (int p = 0; p < N_CORE; p++) begin
`ifdef GC_DISPATCH_RR_EN
                    idx = (int'(ptr_q) + p) % N_CORE;
`else
                    idx = p;
`endif
                    if (req_valid[idx]) begin
                        if (done_seen_q[idx]) begin
                            req_ready[idx]                      = 1'b1;
                            gc_out[idx*GC_WIDTH +: GC_WIDTH]    = cur;
                            gc_done[idx]                        = 1'b1;
`ifdef GC_DISPATCH_RR_EN
                            last      = idx;
                            any_grant = 1'b1;
`endif
                        end else if (slots < MAX_GRANT) begin
                            req_ready[idx]                      = 1'b1;
                            gc_out[idx*GC_WIDTH +: GC_WIDTH]    = cur;
                            if (frozen || out_of_range(cur, bound_q, gd_q[GD_WIDTH-1])) begin
                                gc_done[idx] = 1'b1;
                                frozen       = 1'b1;
                            end else begin
                                cur = cur + gd_ext;
                            end
                            slots = slots + 1;
`ifdef GC_DISPATCH_RR_EN
                            last      = idx;
                            any_grant = 1'b1;
`endif
                        end
                    end
                end
                gc_d        = cur;
                exhausted_d = frozen;
                done_seen_d = done_seen_q | gc_done;
`ifdef GC_DISPATCH_RR_EN
                if (any_grant) begin
                    ptr_d = PTR_W'((last + 1) % N_CORE);
                end
`endif
                if (&done_seen_d) begin
                    state_d = JOIN;
                end
            end
            JOIN: begin
                if (&ending) begin
                    join_valid = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gc_q        <= '0;
            gd_q        <= '0;
            bound_q     <= '0;
            done_seen_q <= '0;
            exhausted_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gc_q        <= gc_d;
            gd_q        <= gd_d;
            bound_q     <= bound_d;
            done_seen_q <= done_seen_d;
            exhausted_q <= exhausted_d;
        end
    end

`ifdef GC_DISPATCH_RR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

endmodule
`default_nettype wire
